// File: rtl/dsm2_bitstream_gen.sv
// Second-order delta-sigma modulator: turns one clipped signed DC sample into
// a fixed-length 1-bit stream (1 = +FS, 0 = -FS) for a bitstream decimator.
module dsm2_bitstream_gen #(
    parameter int IN_W     = 16,
    parameter int N_CYCLES = 1024,
    parameter int LIM      = 24576
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   start,
    input  logic signed [IN_W-1:0] x_in,
    output logic                   d_out,
    output logic                   d_valid,
    output logic                   busy,
    output logic                   done,
    output logic [10:0]            ones_count
);

    localparam int I1_W  = IN_W + 3;
    localparam int I2_W  = IN_W + 5;
    localparam int SUM_W = IN_W + 7;
    localparam int CNT_W = 11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic signed [IN_W-1:0]  CLIP_HI = IN_W'(LIM - 1);
    localparam logic signed [IN_W-1:0]  CLIP_LO = IN_W'(-LIM);
    localparam logic signed [SUM_W-1:0] FB_MAG  = SUM_W'(2 ** (IN_W - 1));
    localparam logic signed [SUM_W-1:0] I1_MAX  = SUM_W'((2 ** (I1_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] I1_MIN  = SUM_W'(-(2 ** (I1_W - 1)));
    localparam logic signed [SUM_W-1:0] I2_MAX  = SUM_W'((2 ** (I2_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] I2_MIN  = SUM_W'(-(2 ** (I2_W - 1)));
    localparam logic [CNT_W-1:0]        LAST    = CNT_W'(N_CYCLES - 1);

    logic [1:0]              state;
    logic [CNT_W-1:0]        bit_cnt;
    logic signed [IN_W-1:0]  x_reg;
    logic signed [I1_W-1:0]  i1;
    logic signed [I2_W-1:0]  i2;

    logic                    y;
    logic                    accept;
    logic signed [SUM_W-1:0] fb;
    logic signed [SUM_W-1:0] sum1;
    logic signed [SUM_W-1:0] sum2;

    // Input clip keeps the second-order loop inside its stable range.
    function automatic logic signed [IN_W-1:0] clip_in(input logic signed [IN_W-1:0] v);
        if (v > CLIP_HI)
            return CLIP_HI;
        else if (v < CLIP_LO)
            return CLIP_LO;
        else
            return v;
    endfunction

    // Saturate a wide sum into the first integrator range.
    function automatic logic signed [I1_W-1:0] sat_i1(input logic signed [SUM_W-1:0] v);
        if (v > I1_MAX)
            return I1_MAX[I1_W-1:0];
        else if (v < I1_MIN)
            return I1_MIN[I1_W-1:0];
        else
            return v[I1_W-1:0];
    endfunction

    // Saturate a wide sum into the second integrator range.
    function automatic logic signed [I2_W-1:0] sat_i2(input logic signed [SUM_W-1:0] v);
        if (v > I2_MAX)
            return I2_MAX[I2_W-1:0];
        else if (v < I2_MIN)
            return I2_MIN[I2_W-1:0];
        else
            return v[I2_W-1:0];
    endfunction

    // Quantiser, feedback and integrator updates; i2 uses the old i1.
    always_comb begin
        y      = (i2 >= 0);
        fb     = y ? FB_MAG : -FB_MAG;
        sum1   = SUM_W'(i1) + SUM_W'(x_reg) - fb;
        sum2   = SUM_W'(i2) + SUM_W'(i1) - fb;
        // A start is only taken in IDLE or once done is visible; in RUN and on
        // the first DONE cycle it is ignored.
        accept = start && ((state == S_IDLE) || ((state == S_DONE) && done));
    end

    // Conversion sequencing, output flags and the ones counter.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            d_out      <= 1'b0;
            d_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ones_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state      <= S_RUN;
                        bit_cnt    <= '0;
                        ones_count <= '0;
                        done       <= 1'b0;
                    end
                end
                S_RUN: begin
                    d_out      <= y;
                    d_valid    <= 1'b1;
                    busy       <= 1'b1;
                    ones_count <= ones_count + 11'(y);
                    bit_cnt    <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST)
                        state <= S_DONE;
                end
                S_DONE: begin
                    d_valid <= 1'b0;
                    busy    <= 1'b0;
                    if (accept) begin
                        state      <= S_RUN;
                        bit_cnt    <= '0;
                        ones_count <= '0;
                        done       <= 1'b0;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sample capture and loop integrators; they hold outside RUN.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            x_reg <= '0;
            i1    <= '0;
            i2    <= '0;
        end else if (accept) begin
            x_reg <= clip_in(x_in);
            i1    <= '0;
            i2    <= '0;
        end else if (state == S_RUN) begin
            i1 <= sat_i1(sum1);
            i2 <= sat_i2(sum2);
        end
    end

endmodule

// File: tb/tb_dsm2_bitstream_gen.sv
// Directed bench for dsm2_bitstream_gen: reset/idle, x=0 pattern, clipping,
// ignored mid-run start, mid-run reset, linearity and DONE-entry start.
module tb_dsm2_bitstream_gen;

    localparam int N = 1024;

    logic               clk = 1'b0;
    logic               rst_in;
    logic               start;
    logic signed [15:0] x_in;
    logic               d_out;
    logic               d_valid;
    logic               busy;
    logic               done;
    logic [10:0]        ones_count;

    int checks = 0;
    int errors = 0;

    logic cur [N];
    logic saved [N];
    logic model_bits [N];
    int   model_ones;
    int   o_neg, o_zero, o_pos, o_a;

    dsm2_bitstream_gen dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .start      (start),
        .x_in       (x_in),
        .d_out      (d_out),
        .d_valid    (d_valid),
        .busy       (busy),
        .done       (done),
        .ones_count (ones_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic longint sat(input longint v, input longint lim);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // Reference modulator written from the loop equations.
    task automatic build_model(input int x);
        longint i1, i2, n1, n2, xr, fb;
        logic   y;
        i1 = 0;
        i2 = 0;
        xr = (x > 24575) ? 24575 : ((x < -24576) ? -24576 : x);
        model_ones = 0;
        for (int k = 0; k < N; k++) begin
            y  = (i2 >= 0);
            fb = y ? 32768 : -32768;
            n1 = sat(i1 + xr - fb, 262144);
            n2 = sat(i2 + i1 - fb, 1048576);
            i1 = n1;
            i2 = n2;
            model_bits[k] = y;
            model_ones += int'(y);
        end
    endtask

    function automatic int model_diffs();
        int d = 0;
        for (int k = 0; k < N; k++)
            if (cur[k] !== model_bits[k]) d++;
        return d;
    endfunction

    function automatic int pattern_diffs();
        int  d = 0;
        logic e;
        for (int k = 0; k < N; k++) begin
            e = ((k % 4) == 0) || ((k % 4) == 3);
            if (cur[k] !== e) d++;
        end
        return d;
    endfunction

    function automatic int saved_diffs();
        int d = 0;
        for (int k = 0; k < N; k++)
            if (cur[k] !== saved[k]) d++;
        return d;
    endfunction

    // One full conversion; optionally pulses start with dx before bit dist_at.
    task automatic conv(input logic signed [15:0] x, input int dist_at,
                        input logic signed [15:0] dx);
        int badv;
        x_in  = x;
        start = 1'b1;
        tick();
        start = 1'b0;
        x_in  = 16'sd0;
        chk("t0_d_valid", {31'd0, d_valid}, 32'd0);
        chk("t0_busy", {31'd0, busy}, 32'd0);
        chk("t0_done", {31'd0, done}, 32'd0);
        badv = 0;
        for (int k = 0; k < N; k++) begin
            if (k == dist_at) begin
                start = 1'b1;
                x_in  = dx;
            end
            tick();
            start = 1'b0;
            cur[k] = d_out;
            if (d_valid !== 1'b1 || busy !== 1'b1) badv++;
        end
        tick();
        chk("valid_window", badv, 0);
        chk("end_d_valid", {31'd0, d_valid}, 32'd0);
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("end_done", {31'd0, done}, 32'd1);
        chk("end_d_out_hold", {31'd0, d_out}, {31'd0, cur[N-1]});
        tick();
        chk("done_stable", {31'd0, done}, 32'd1);
        o_a = int'(ones_count);
    endtask

    initial begin
        int bad;
        rst_in = 1'b1;
        start  = 1'b0;
        x_in   = 16'sd0;

        // Reset for three cycles, then idle for twenty with no start.
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if ({d_out, d_valid, busy, done} !== 4'b0 || ones_count !== 11'd0) bad++;
        end
        rst_in = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if ({d_out, d_valid, busy, done} !== 4'b0 || ones_count !== 11'd0) bad++;
        end
        chk("reset_idle_outputs", bad, 0);

        // Zero input: 1,0,0,1 repeating, half ones.
        conv(16'sd0, -1, 16'sd0);
        chk("zero_pattern", pattern_diffs(), 0);
        chk("zero_ones", o_a, 512);

        // Largest unclipped positive input.
        conv(16'sd24575, -1, 16'sd0);
        build_model(24575);
        chk("pos_model_stream", model_diffs(), 0);
        chk("pos_model_ones", o_a, model_ones);
        chk_range("pos_ones", o_a, 895, 897);
        for (int k = 0; k < N; k++) saved[k] = cur[k];

        // Full-scale positive is clipped to the same stream.
        conv(16'sd32767, -1, 16'sd0);
        chk("clip_pos_same_stream", saved_diffs(), 0);
        chk_range("clip_pos_ones", o_a, 895, 897);

        // Full-scale negative is clipped to -24576.
        conv(-16'sd32768, -1, 16'sd0);
        build_model(-24576);
        chk("clip_neg_model_stream", model_diffs(), 0);
        chk_range("clip_neg_ones", o_a, 127, 129);

        // Start pulsed mid-run with another sample is ignored.
        conv(16'sd0, 100, 16'sd12345);
        chk("midrun_start_pattern", pattern_diffs(), 0);
        chk("midrun_start_ones", o_a, 512);

        // Reset at bit 300 clears everything, then a clean restart.
        x_in  = 16'sd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 300; k++) tick();
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("midrun_reset_flags", {28'd0, d_out, d_valid, busy, done}, 32'd0);
        chk("midrun_reset_ones", {21'd0, ones_count}, 32'd0);
        tick();
        chk("after_reset_idle", {28'd0, d_out, d_valid, busy, done}, 32'd0);
        conv(16'sd0, -1, 16'sd0);
        chk("restart_pattern", pattern_diffs(), 0);

        // Linearity sweep.
        conv(-16'sd16384, -1, 16'sd0);
        o_neg = o_a;
        build_model(-16384);
        chk("lin_neg_model_stream", model_diffs(), 0);
        chk_range("lin_neg_ones", o_neg, 254, 258);
        conv(16'sd0, -1, 16'sd0);
        o_zero = o_a;
        conv(16'sd8192, -1, 16'sd0);
        o_pos = o_a;
        build_model(8192);
        chk("lin_pos_model_stream", model_diffs(), 0);
        chk_range("lin_pos_ones", o_pos, 638, 642);
        chk_range("lin_slope", 2 * (o_pos - o_zero) - (o_zero - o_neg), -4, 4);

        // Start held from the DONE-entry cycle: first edge ignored, second taken.
        x_in  = 16'sd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < N; k++) tick();
        start = 1'b1;
        tick();
        chk("done_entry_start_ignored", {29'd0, d_valid, busy, done}, 32'd1);
        tick();
        start = 1'b0;
        chk("b2b_done_dropped", {29'd0, d_valid, busy, done}, 32'd0);
        chk("b2b_ones_cleared", {21'd0, ones_count}, 32'd0);
        tick();
        chk("b2b_first_bit", {29'd0, d_out, d_valid, busy}, 32'd7);
        tick();
        chk("b2b_second_bit", {30'd0, d_out, d_valid}, 32'd1);
        chk("b2b_ones_after_two", {21'd0, ones_count}, 32'd1);

        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
